bck_slot_scheduler: RTL and testbench

Slot scheduler for the backward-extension loop of the SMEM pipeline. It sits at the loop-back point, where the token leaving the last stage re-enters CONTROL_STAGE2. Each cycle it classifies the returning token's slot: a live read recirculates, a finished read is retired, and a free slot is refilled with the next read of the current batch or filled with a bubble. It also tracks reads in flight and signals batch completion.

---
 rtl/bck_slot_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_bck_slot_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bck_slot_scheduler.sv
// ============================================================================
// bck_slot_scheduler
// ----------------------------------------------------------------------------
// Slot scheduler for the backward-extension loop of the SMEM pipeline. It sits
// at the loop-back point. Each cycle it looks at the token leaving the last
// stage and decides what the loop-entry mux feeds into CONTROL_STAGE2:
//   - a live read keeps circulating (inj_sel_o = 0),
//   - a finished read is retired and its slot is freed,
//   - a free slot gets the next read of the batch (BCK_INI) or a bubble.
// It also counts reads in flight and pulses done_o when a batch has drained.
//
// Ports:
//   clk, rst           clock; synchronous active-low reset
//   start_i            pulse, begins a batch (accepted only in IDLE)
//   batch_size_i       number of reads in the batch, latched on start
//   stall_i            global pipeline stall, freezes the scheduler
//   ret_status_i       status code of the returning token
//   ret_finish_i       finish_sign of the returning token
//   ret_read_num_i     read index of the returning token
//   inj_sel_o          1 = mux takes inj_* fields, 0 = recirculate
//   inj_status_o       BCK_INI or BUBBLE when inj_sel_o = 1
//   inj_read_num_o     read index being injected
//   retire_valid_o     one-cycle pulse per finished read
//   retire_read_num_o  index of the retired read
//   in_flight_o        reads currently in the loop
//   busy_o             scheduler is not IDLE
//   done_o             one-cycle pulse at batch completion
//   err_o              sticky protocol error
// All outputs are registered: they reflect the ret_* inputs sampled on the
// previous non-stall edge.
// ============================================================================
module bck_slot_scheduler #(
    parameter int         READ_NUM_WIDTH = 10,
    parameter int         MAX_INFLIGHT   = 16,
    parameter logic [5:0] BUBBLE         = 6'h00,
    parameter logic [5:0] BCK_INI        = 6'h04,
    parameter logic [5:0] BCK_RUN        = 6'h05
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start_i,
    input  logic [READ_NUM_WIDTH:0]             batch_size_i,
    input  logic                                stall_i,
    input  logic [5:0]                          ret_status_i,
    input  logic                                ret_finish_i,
    input  logic [READ_NUM_WIDTH-1:0]           ret_read_num_i,
    output logic                                inj_sel_o,
    output logic [5:0]                          inj_status_o,
    output logic [READ_NUM_WIDTH-1:0]           inj_read_num_o,
    output logic                                retire_valid_o,
    output logic [READ_NUM_WIDTH-1:0]           retire_read_num_o,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   in_flight_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                err_o
);

    // Counters are one bit wider than the read index so that a batch of
    // exactly 2^READ_NUM_WIDTH reads can be issued and counted without wrap.
    localparam int CW  = READ_NUM_WIDTH + 1;
    localparam int RW  = READ_NUM_WIDTH;
    localparam int IFW = $clog2(MAX_INFLIGHT + 1);

    localparam logic [IFW-1:0] IF_MAX  = IFW'(MAX_INFLIGHT);
    localparam logic [IFW-1:0] IF_ONE  = IFW'(1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   batchSize_q, batchSize_d;
    logic [CW-1:0]   nextRead_q, nextRead_d;
    logic [CW-1:0]   doneCnt_q, doneCnt_d;
    logic [IFW-1:0]  inFlight_q, inFlight_d;
    logic            injSel_q, injSel_d;
    logic [5:0]      injStatus_q, injStatus_d;
    logic [RW-1:0]   injReadNum_q, injReadNum_d;
    logic            retireValid_q, retireValid_d;
    logic [RW-1:0]   retireReadNum_q, retireReadNum_d;
    logic            busy_q;
    logic            done_q;
    logic            err_q, err_d;

    logic            statusKnown;
    logic            slotLive;
    logic            retiring;
    logic            underflow;
    logic [IFW-1:0]  inFlightAfterRetire;
    logic            canInject;

    // Slot classification and refill decision for the returning token.
    // Unknown status codes are treated as free slots but flag an error.
    // A retire with nothing in flight is an error and must not underflow the
    // counter. The refill check uses the in-flight count after this cycle's
    // retire, so a slot freed by a finishing read can be refilled at once.
    always_comb begin
        statusKnown = (ret_status_i == BUBBLE) || (ret_status_i == BCK_INI) ||
                      (ret_status_i == BCK_RUN);
        retiring    = (ret_status_i == BCK_RUN) && ret_finish_i;
        slotLive    = (ret_status_i == BCK_INI) ||
                      ((ret_status_i == BCK_RUN) && !ret_finish_i);
        underflow   = retiring && (inFlight_q == '0);

        inFlightAfterRetire = inFlight_q;
        if (retiring && !underflow) begin
            inFlightAfterRetire = inFlight_q - IF_ONE;
        end

        canInject = !slotLive && (state_q == RUN) &&
                    (nextRead_q < batchSize_q) &&
                    (inFlightAfterRetire < IF_MAX);
    end

    // Loop-entry mux control, retire reporting and counter updates.
    // Finished tokens are never recirculated: their slot becomes either a new
    // read or a bubble.
    always_comb begin
        injSel_d        = 1'b1;
        injStatus_d     = BUBBLE;
        injReadNum_d    = '0;
        retireValid_d   = retiring;
        retireReadNum_d = retiring ? ret_read_num_i : retireReadNum_q;
        nextRead_d      = nextRead_q;
        doneCnt_d       = retiring ? (doneCnt_q + CNT_ONE) : doneCnt_q;
        inFlight_d      = inFlightAfterRetire;
        err_d           = err_q || !statusKnown || underflow;

        if (slotLive) begin
            injSel_d = 1'b0;
        end else if (canInject) begin
            injStatus_d  = BCK_INI;
            injReadNum_d = nextRead_q[RW-1:0];
            nextRead_d   = nextRead_q + CNT_ONE;
            inFlight_d   = inFlightAfterRetire + IF_ONE;
        end

        // Batch sequencing. Starting a batch clears the issue and completion
        // counters; an empty batch goes straight to DONE.
        state_d     = state_q;
        batchSize_d = batchSize_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    batchSize_d = batch_size_i;
                    nextRead_d  = '0;
                    doneCnt_d   = '0;
                    state_d     = (batch_size_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (nextRead_q == batchSize_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (doneCnt_q == batchSize_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset flushes the loop with bubbles and
    // abandons any batch. During a stall everything holds except the two
    // pulse outputs, which drop so that no retire or completion is reported
    // twice.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            batchSize_q     <= '0;
            nextRead_q      <= '0;
            doneCnt_q       <= '0;
            inFlight_q      <= '0;
            injSel_q        <= 1'b1;
            injStatus_q     <= BUBBLE;
            injReadNum_q    <= '0;
            retireValid_q   <= 1'b0;
            retireReadNum_q <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else if (stall_i) begin
            retireValid_q   <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            batchSize_q     <= batchSize_d;
            nextRead_q      <= nextRead_d;
            doneCnt_q       <= doneCnt_d;
            inFlight_q      <= inFlight_d;
            injSel_q        <= injSel_d;
            injStatus_q     <= injStatus_d;
            injReadNum_q    <= injReadNum_d;
            retireValid_q   <= retireValid_d;
            retireReadNum_q <= retireReadNum_d;
            busy_q          <= (state_d != IDLE);
            done_q          <= (state_d == DONE);
            err_q           <= err_d;
        end
    end

    assign inj_sel_o         = injSel_q;
    assign inj_status_o      = injStatus_q;
    assign inj_read_num_o    = injReadNum_q;
    assign retire_valid_o    = retireValid_q;
    assign retire_read_num_o = retireReadNum_q;
    assign in_flight_o       = inFlight_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_bck_slot_scheduler.sv
// ============================================================================
// tb_bck_slot_scheduler
// ----------------------------------------------------------------------------
// Self-checking bench for bck_slot_scheduler. Reads in the loop are kept as a
// queue of read indices; returning tokens are drawn at random from that set
// (live, finishing) or are bubbles. A behavioural model predicts every
// registered output one cycle after the inputs are applied.
// Small parameters are used so that the in-flight cap and the full-width
// batch size (2^READ_NUM_WIDTH) are both reachable quickly.
// ============================================================================
module tb_bck_slot_scheduler;

    localparam int RW    = 4;
    localparam int MAXIF = 3;
    localparam int IFW   = $clog2(MAXIF + 1);

    localparam logic [5:0] ST_BUBBLE = 6'h00;
    localparam logic [5:0] ST_INI    = 6'h04;
    localparam logic [5:0] ST_RUN    = 6'h05;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [RW:0]    batchSize;
    logic           stall;
    logic [5:0]     retStatus;
    logic           retFinish;
    logic [RW-1:0]  retReadNum;
    logic           injSel;
    logic [5:0]     injStatus;
    logic [RW-1:0]  injReadNum;
    logic           retireValid;
    logic [RW-1:0]  retireReadNum;
    logic [IFW-1:0] inFlight;
    logic           busy;
    logic           done;
    logic           err;

    int numChecks = 0;
    int numFails  = 0;

    // Behavioural model: batch phase, issue/complete counts and the set of
    // reads believed to be in the loop.
    int         mPhase;
    int         mBatch;
    int         mIssued;
    int         mFinished;
    bit         mErr;
    int         liveReads[$];
    bit         expInjSel;
    logic [5:0] expInjStatus;
    int         expInjNum;
    bit         expRetV;
    int         expRetNum;
    bit         expBusy;
    bit         expDone;

    bck_slot_scheduler #(
        .READ_NUM_WIDTH (RW),
        .MAX_INFLIGHT   (MAXIF),
        .BUBBLE         (ST_BUBBLE),
        .BCK_INI        (ST_INI),
        .BCK_RUN        (ST_RUN)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start_i           (start),
        .batch_size_i      (batchSize),
        .stall_i           (stall),
        .ret_status_i      (retStatus),
        .ret_finish_i      (retFinish),
        .ret_read_num_i    (retReadNum),
        .inj_sel_o         (injSel),
        .inj_status_o      (injStatus),
        .inj_read_num_o    (injReadNum),
        .retire_valid_o    (retireValid),
        .retire_read_num_o (retireReadNum),
        .in_flight_o       (inFlight),
        .busy_o            (busy),
        .done_o            (done),
        .err_o             (err)
    );

    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Predicts the outputs produced by the edge that samples the current
    // inputs. Transition decisions use the counts from before this cycle.
    task automatic modelStep();
        bit known;
        bit retiring;
        bit live;
        int idx;
        int oldIssued;
        int oldFinished;
        if (!rst) begin
            mPhase = P_IDLE; mBatch = 0; mIssued = 0; mFinished = 0; mErr = 0;
            liveReads.delete();
            expInjSel = 1; expInjStatus = ST_BUBBLE; expInjNum = 0;
            expRetV = 0; expRetNum = 0; expBusy = 0; expDone = 0;
            return;
        end
        if (stall) begin
            expRetV = 0;
            expDone = 0;
            return;
        end
        oldIssued   = mIssued;
        oldFinished = mFinished;
        known    = (retStatus == ST_BUBBLE) || (retStatus == ST_INI) || (retStatus == ST_RUN);
        retiring = (retStatus == ST_RUN) && retFinish;
        live     = (retStatus == ST_INI) || ((retStatus == ST_RUN) && !retFinish);
        if (!known) mErr = 1;
        expRetV = retiring;
        if (retiring) begin
            expRetNum = int'(retReadNum);
            mFinished++;
            if (liveReads.size() == 0) begin
                mErr = 1;
            end else begin
                idx = -1;
                foreach (liveReads[i]) if (idx < 0 && liveReads[i] == int'(retReadNum)) idx = i;
                if (idx < 0) idx = 0;
                liveReads.delete(idx);
            end
        end
        if (live) begin
            expInjSel = 0;
        end else if (mPhase == P_RUN && mIssued < mBatch && liveReads.size() < MAXIF) begin
            expInjSel = 1; expInjStatus = ST_INI; expInjNum = mIssued;
            liveReads.push_back(mIssued);
            mIssued++;
        end else begin
            expInjSel = 1; expInjStatus = ST_BUBBLE; expInjNum = 0;
        end
        case (mPhase)
            P_IDLE: if (start) begin
                mBatch = int'(batchSize); mIssued = 0; mFinished = 0;
                mPhase = (mBatch == 0) ? P_DONE : P_RUN;
            end
            P_RUN:   if (oldIssued == mBatch) mPhase = P_DRAIN;
            P_DRAIN: if (oldFinished == mBatch) mPhase = P_DONE;
            default: mPhase = P_IDLE;
        endcase
        expBusy = (mPhase != P_IDLE);
        expDone = (mPhase == P_DONE);
    endtask

    task automatic compareAll();
        checkOutput("injSel", 32'(injSel), 32'(expInjSel));
        if (expInjSel) begin
            checkOutput("injStatus", 32'(injStatus), 32'(expInjStatus));
            checkOutput("injReadNum", 32'(injReadNum), 32'(expInjNum));
        end
        checkOutput("retireValid", 32'(retireValid), 32'(expRetV));
        if (expRetV) checkOutput("retireReadNum", 32'(retireReadNum), 32'(expRetNum));
        checkOutput("inFlight", 32'(inFlight), 32'(liveReads.size()));
        checkOutput("busy", 32'(busy), 32'(expBusy));
        checkOutput("done", 32'(done), 32'(expDone));
        checkOutput("err", 32'(err), 32'(mErr));
    endtask

    // Inputs are set at the falling edge; predict, clock, then compare.
    task automatic tick();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        compareAll();
    endtask

    task automatic setBubble();
        retStatus  = ST_BUBBLE;
        retFinish  = 1'b0;
        retReadNum = '0;
    endtask

    // Random returning token: live or finishing tokens come from reads that
    // are really in the loop; everything else is a bubble.
    task automatic applyStimulus(input int stallPct, input int livePct, input int finPct);
        int r;
        int idx;
        stall      = ($urandom_range(0, 99) < stallPct);
        r          = $urandom_range(0, 99);
        retReadNum = RW'($urandom);
        retFinish  = 1'($urandom);
        retStatus  = ST_BUBBLE;
        if (liveReads.size() > 0 && r < livePct + finPct) begin
            idx        = $urandom_range(0, liveReads.size() - 1);
            retReadNum = RW'(liveReads[idx]);
            if (r < livePct) begin
                retStatus = ($urandom_range(0, 1) == 1) ? ST_INI : ST_RUN;
                if (retStatus == ST_RUN) retFinish = 1'b0;
            end else begin
                retStatus = ST_RUN;
                retFinish = 1'b1;
            end
        end
    endtask

    task automatic doReset();
        rst = 1'b0; start = 1'b0; stall = 1'b0; batchSize = '0;
        setBubble();
        repeat (3) tick();
        checkOutput("rstRetireNum", 32'(retireReadNum), 32'(0));
        rst = 1'b1;
    endtask

    // Runs random traffic (with spurious start pulses that must be ignored)
    // until the model returns to idle or the cycle budget runs out.
    task automatic runUntilIdle(input int stallPct, input int budget);
        int cyc = 0;
        while (mPhase != P_IDLE && cyc < budget) begin
            applyStimulus(stallPct, 35, 30);
            start     = ($urandom_range(0, 9) == 0);
            batchSize = (RW+1)'($urandom);
            tick();
            cyc++;
        end
        start = 1'b0;
        checkOutput("batchEnds", 32'(busy), 32'(0));
    endtask

    task automatic startBatch(input int bs);
        stall     = 1'b0;
        start     = 1'b1;
        batchSize = bs[RW:0];
        setBubble();
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stall = 1'b0; batchSize = '0;
        setBubble();

        // Reset and a quiet loop of bubbles.
        doReset();
        repeat (20) tick();

        // Start ignored while stalled.
        stall = 1'b1; start = 1'b1; batchSize = 5'd4;
        tick();
        start = 1'b0; stall = 1'b0;
        tick();

        // Batch of 3 with only bubbles returning: reads 0,1,2 back to back.
        startBatch(3);
        repeat (6) tick();
        runUntilIdle(0, 400);

        // In-flight cap, then retire and refill in the same slot.
        doReset();
        startBatch(8);
        repeat (4) tick();
        retStatus = ST_RUN; retFinish = 1'b1; retReadNum = 4'd1;
        tick();
        setBubble();
        tick();
        runUntilIdle(20, 1000);

        // Heavy stalling around the end of a batch.
        startBatch(3);
        runUntilIdle(40, 1000);

        // Full-width batch size.
        startBatch(16);
        runUntilIdle(15, 2000);

        // Random batches.
        for (int b = 0; b < 10; b++) begin
            startBatch($urandom_range(1, 16));
            runUntilIdle($urandom_range(0, 30), 2000);
        end

        // Reset mid-batch abandons the reads.
        startBatch(10);
        repeat (6) begin
            applyStimulus(0, 40, 20);
            tick();
        end
        doReset();
        repeat (3) tick();

        // Retire with nothing in flight: sticky error.
        retStatus = ST_RUN; retFinish = 1'b1; retReadNum = 4'd5;
        tick();
        setBubble();
        repeat (3) tick();

        // Unknown status code: error.
        doReset();
        retStatus = 6'h2A; retFinish = 1'b0; retReadNum = 4'd3;
        tick();
        setBubble();
        tick();

        // Empty batch: done next cycle, nothing injected.
        doReset();
        startBatch(0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
